hf_ssp_byte_framer: RTL and testbench
=====================================

// Module: hf_ssp_byte_framer
// PURPOSE
//   Downstream of the ISO14443-A modulation detector: packs the per-16-tick demodulated bits (curbit)
//   into bytes, buffers them, and serialises them to the ARM over SSP (ssp_clk = carrier/16,
//   one ssp_frame per 128-tick byte slot), MSB first.
//   Replaces the ad-hoc to_arm/ssp_clk/ssp_frame logic in the HF top level with one self-contained stage.
// PARAMETERS
//   FIFO_DEPTH   2    byte entries between assembler and serialiser (power of 2, >=2)
//   FRAME_RISE   7    tick (0..127) at which ssp_frame is set
//   FRAME_FALL   23   tick at which ssp_frame is cleared
//   IDLE_BYTE    8'h00 byte sent in a slot when the FIFO is empty
// PORTS
//   ck_1356meg   in   1  13.56 MHz carrier clock; all state updates on its falling edge
//   nrst         in   1  asynchronous, active-low reset
//   enable       in   1  1 = framer running; 0 = hold idle, flush
//   bit_in       in   1  demodulated bit (1 = modulation detected)
//   bit_valid    in   1  one-tick strobe: bit_in is valid this tick
//   bit_align    in   1  one-tick strobe: discard partially assembled byte, restart at bit 7
//   ovf_clr      in   1  one-tick strobe: clear sticky overflow
//   ssp_clk      out  1  SSP bit clock to ARM
//   ssp_frame    out  1  SSP frame marker
//   ssp_din      out  1  SSP serial data to ARM
//   overflow     out  1  sticky: a completed byte was dropped because the FIFO was full
// BEHAVIOUR
//   - Reset (nrst=0, async): tick=0, bit count=0, FIFO empty, shift reg=IDLE_BYTE;
//     ssp_clk=0, ssp_frame=0, ssp_din=0, overflow=0.
//   - enable=0: same state as reset except overflow is kept; all outputs held 0.
//     enable deasserted mid-byte -> partial byte and FIFO contents are discarded.
//   - Tick counter: 7-bit, counts 0..127 and wraps to 0 while enable=1; the first tick after enable rises is 0.
//   - ssp_clk: registered; set when tick[3:0]==0, cleared when tick[3:0]==8 (50% duty, period 16).
//   - ssp_frame: set when tick==FRAME_RISE, cleared when tick==FRAME_FALL.
//   - Serialiser: at tick==0, pop FIFO head into shift reg (or load IDLE_BYTE if empty).
//     At tick[3:0]==0 with tick!=0, shift left by one. ssp_din is registered from shift[7]
//     on the same tick, so bit 7 appears at tick 0 and bit 0 at tick 112. Latency from byte push to
//     first bit on ssp_din is at most one slot (128 ticks) plus one tick.
//   - Assembler: on bit_valid, shift bit_in into an 8-bit reg (first bit ends up as MSB) and increment
//     the 3-bit count. When the count wraps 7->0, push the byte to the FIFO.
//   - bit_align has priority over bit_valid in the same tick: count=0, the bit is discarded.
//   - FIFO full on push: the byte is dropped and overflow is set. Exception: a pop in the same tick
//     (tick==0) is applied first, so the push succeeds and no overflow occurs.
//   - Empty FIFO on pop -> IDLE_BYTE is sent and no state changes.
//   - ovf_clr in the same tick as a new overflow: set wins.
//   - Widths: tick 7b, bit count 3b, FIFO pointers log2(FIFO_DEPTH)+1 b (wrap-bit full/empty).
// STRUCTURE
//   - Package hf_ssp_pkg holds:
//       - tick constants: TICKS_PER_BIT=16, TICKS_PER_BYTE=128, SSPCLK_FALL=8;
//       - the FRAME_RISE/FRAME_FALL defaults;
//       - typedef byte_t (8b).
//   - One sub-module, hf_byte_fifo (sync FIFO with async active-low reset):
//       - ports push/pop/din/dout/full/empty plus a synchronous flush.
//   - The top holds the tick counter, assembler, serialiser and SSP signal registers.
// TESTING
//   1 Reset/idle: enable=1, no bit_valid, run 256 ticks. Expect:
//       - ssp_din=0 throughout;
//       - ssp_clk high at ticks 1..8 of every 16 (registered);
//       - ssp_frame high for ticks 8..23 of each 128.
//   2 Single byte: strobe bits 1,0,1,1,0,0,1,0 (one per 16 ticks), then nothing. Expect:
//       - the next slot serialises 0xB2 MSB first (ssp_din 1,0,1,1,0,0,1,0 at ticks 0,16,..,112);
//       - the following slot sends 0x00.
//   3 Overflow: push 3 bytes inside one slot with FIFO_DEPTH=2. Expect:
//       - overflow=1, and the third byte never appears on ssp_din;
//       - ovf_clr pulse -> overflow=0.
//   4 Push/pop collision: FIFO full, the 8th bit_valid lands at tick 0. Expect:
//       - head popped and new byte accepted, overflow stays 0;
//       - 3 bytes emerge in order.
//   5 Align: 5 bits strobed, bit_align, then 8 bits of 0x5A. Expect:
//       - only 0x5A is emitted;
//       - bit_align together with bit_valid discards that bit.
//   6 Mid-op abort: assert nrst=0 (async, off-edge) at tick 50 of a 0xFF slot. Expect:
//       - all outputs 0 immediately;
//       - after release, FIFO empty and the first slot sends IDLE_BYTE.

Source files
------------

// File: rtl/hf_ssp_pkg.sv
// Shared constants and types for the HF SSP byte framer.
package hf_ssp_pkg;

  localparam int unsigned TICK_W         = 7;
  localparam int unsigned BCNT_W         = 3;
  localparam int unsigned TICKS_PER_BIT  = 16;
  localparam int unsigned TICKS_PER_BYTE = 128;
  localparam int unsigned SSPCLK_FALL    = 8;
  localparam int unsigned FRAME_RISE_DEF = 7;
  localparam int unsigned FRAME_FALL_DEF = 23;

  typedef logic [7:0] byte_t;

endpackage

// File: rtl/hf_byte_fifo.sv
// Byte FIFO between assembler and serialiser; wrap-bit pointers, captures on the falling clock edge.
module hf_byte_fifo
  import hf_ssp_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  i_flush,
  input  logic  i_push,
  input  logic  i_pop,
  input  byte_t i_din,
  output byte_t o_dout,
  output logic  o_full,
  output logic  o_empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  byte_t         r_mem [DEPTH];
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_dout    = r_mem[r_rd_ptr[AW-1:0]];
  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
    end
  end

  always_ff @(negedge clk) begin
    if (w_do_push && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/hf_ssp_byte_framer.sv
// Packs demodulated bits into bytes and serialises them MSB first over SSP, one byte per 128-tick slot.
module hf_ssp_byte_framer
  import hf_ssp_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned FRAME_RISE = FRAME_RISE_DEF,
  parameter int unsigned FRAME_FALL = FRAME_FALL_DEF,
  parameter byte_t       IDLE_BYTE  = 8'h00
) (
  input  logic ck_1356meg,
  input  logic nrst,
  input  logic enable,
  input  logic bit_in,
  input  logic bit_valid,
  input  logic bit_align,
  input  logic ovf_clr,
  output logic ssp_clk,
  output logic ssp_frame,
  output logic ssp_din,
  output logic overflow
);

  localparam int unsigned PHASE_W = $clog2(TICKS_PER_BIT);

  logic [TICK_W-1:0]  r_tick;
  logic [BCNT_W-1:0]  r_bcnt;
  logic [6:0]         r_asm;
  logic [6:0]         r_shift;
  logic               r_ssp_clk;
  logic               r_ssp_frame;
  logic               r_ssp_din;
  logic               r_overflow;

  logic [PHASE_W-1:0] w_phase;
  logic               w_slot_start;
  logic               w_take;
  logic               w_push;
  logic               w_pop;
  logic               w_drop;
  logic               w_full;
  logic               w_empty;
  byte_t              w_asm_next;
  byte_t              w_dout;
  byte_t              w_load;

  assign w_phase      = r_tick[PHASE_W-1:0];
  assign w_slot_start = enable && (r_tick == '0);
  assign w_take       = enable && bit_valid && !bit_align;
  assign w_asm_next   = {r_asm, bit_in};
  assign w_push       = w_take && (&r_bcnt);
  assign w_pop        = w_slot_start && !w_empty;
  assign w_drop       = w_push && w_full && !w_pop;
  assign w_load       = w_empty ? IDLE_BYTE : w_dout;

  hf_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (ck_1356meg),
    .rst_n   (nrst),
    .i_flush (!enable),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_din   (w_asm_next),
    .o_dout  (w_dout),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Tick counter, SSP clock/frame and serialiser; r_shift holds the bits still to send after ssp_din.
  always_ff @(negedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      r_tick      <= '0;
      r_shift     <= IDLE_BYTE[6:0];
      r_ssp_clk   <= 1'b0;
      r_ssp_frame <= 1'b0;
      r_ssp_din   <= 1'b0;
    end else if (!enable) begin
      r_tick      <= '0;
      r_shift     <= IDLE_BYTE[6:0];
      r_ssp_clk   <= 1'b0;
      r_ssp_frame <= 1'b0;
      r_ssp_din   <= 1'b0;
    end else begin
      r_tick <= (r_tick == TICK_W'(TICKS_PER_BYTE - 1)) ? '0 : r_tick + TICK_W'(1);

      if (w_phase == '0)                          r_ssp_clk <= 1'b1;
      else if (w_phase == PHASE_W'(SSPCLK_FALL))  r_ssp_clk <= 1'b0;

      if (r_tick == TICK_W'(FRAME_RISE))          r_ssp_frame <= 1'b1;
      else if (r_tick == TICK_W'(FRAME_FALL))     r_ssp_frame <= 1'b0;

      if (r_tick == '0) begin
        r_shift   <= w_load[6:0];
        r_ssp_din <= w_load[7];
      end else if (w_phase == '0) begin
        r_shift   <= {r_shift[5:0], 1'b0};
        r_ssp_din <= r_shift[6];
      end
    end
  end

  // Bit assembler; alignment wins over a coincident valid bit.
  always_ff @(negedge ck_1356meg or negedge nrst) begin
    if (!nrst) begin
      r_asm  <= '0;
      r_bcnt <= '0;
    end else if (!enable) begin
      r_asm  <= '0;
      r_bcnt <= '0;
    end else if (bit_align) begin
      r_bcnt <= '0;
    end else if (bit_valid) begin
      r_asm  <= w_asm_next[6:0];
      r_bcnt <= r_bcnt + BCNT_W'(1);
    end
  end

  always_ff @(negedge ck_1356meg or negedge nrst) begin
    if (!nrst)        r_overflow <= 1'b0;
    else if (w_drop)  r_overflow <= 1'b1;
    else if (ovf_clr) r_overflow <= 1'b0;
  end

  assign ssp_clk   = r_ssp_clk;
  assign ssp_frame = r_ssp_frame;
  assign ssp_din   = r_ssp_din;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_hf_ssp_byte_framer.sv
// Directed bench for hf_ssp_byte_framer: inputs driven and outputs sampled on the rising edge.
module tb_hf_ssp_byte_framer;

  logic ck_1356meg;
  logic nrst;
  logic enable;
  logic bit_in;
  logic bit_valid;
  logic bit_align;
  logic ovf_clr;
  logic ssp_clk;
  logic ssp_frame;
  logic ssp_din;
  logic overflow;

  int total;
  int bad;
  int tb_tick;

  hf_ssp_byte_framer dut (
    .ck_1356meg (ck_1356meg),
    .nrst       (nrst),
    .enable     (enable),
    .bit_in     (bit_in),
    .bit_valid  (bit_valid),
    .bit_align  (bit_align),
    .ovf_clr    (ovf_clr),
    .ssp_clk    (ssp_clk),
    .ssp_frame  (ssp_frame),
    .ssp_din    (ssp_din),
    .overflow   (overflow)
  );

  initial begin
    ck_1356meg = 1'b0;
    forever #5 ck_1356meg = ~ck_1356meg;
  end

  // One DUT tick; tb_tick tracks the DUT tick counter as seen at the following rising edge.
  task automatic adv();
    @(negedge ck_1356meg);
    if (nrst && enable) tb_tick = (tb_tick + 1) % 128;
    else                tb_tick = 0;
    @(posedge ck_1356meg);
  endtask

  task automatic wait_tick(input int t);
    for (int i = 0; i < 300 && tb_tick != t; i++) adv();
    if (tb_tick != t) begin
      total++; bad++;
      $display("FAIL wait_tick: timed out at tick %0d waiting for tick %0d", tb_tick, t);
    end
  endtask

  task automatic send_bits(input logic [7:0] v, input int start, input int spacing);
    wait_tick(start);
    for (int i = 0; i < 8; i++) begin
      bit_in = v[7-i]; bit_valid = 1'b1;
      adv();
      bit_in = 1'b0; bit_valid = 1'b0;
      for (int j = 1; j < spacing; j++) adv();
    end
  endtask

  // Collects one byte off ssp_din, sampling mid-bit at ticks 8,24,..,120 of the slot.
  task automatic capture_slot(output logic [7:0] b);
    int n;
    n = 0;
    b = 8'h00;
    do begin adv(); n++; end while (tb_tick != 8 && n < 300);
    if (tb_tick != 8) begin
      total++; bad++;
      $display("FAIL capture_slot: timed out at tick %0d", tb_tick);
    end
    for (int k = 0; k < 8; k++) begin
      b[7-k] = ssp_din;
      if (k < 7) for (int j = 0; j < 16; j++) adv();
    end
  endtask

  task automatic test_reset();
    adv(); adv();
    total++; if (ssp_clk !== 1'b0)   begin bad++; $display("FAIL reset_clk: got %b expected 0", ssp_clk); end
    total++; if (ssp_frame !== 1'b0) begin bad++; $display("FAIL reset_frame: got %b expected 0", ssp_frame); end
    total++; if (ssp_din !== 1'b0)   begin bad++; $display("FAIL reset_din: got %b expected 0", ssp_din); end
    total++; if (overflow !== 1'b0)  begin bad++; $display("FAIL reset_ovf: got %b expected 0", overflow); end
    nrst = 1'b1;
    adv(); adv();
    total++; if (ssp_clk !== 1'b0)   begin bad++; $display("FAIL disabled_clk: got %b expected 0", ssp_clk); end
    enable = 1'b1;
  endtask

  task automatic test_idle();
    logic exp_clk;
    logic exp_frame;
    for (int i = 0; i < 256; i++) begin
      adv();
      exp_clk   = ((tb_tick % 16) >= 1) && ((tb_tick % 16) <= 8);
      exp_frame = (tb_tick >= 8) && (tb_tick <= 23);
      total++; if (ssp_clk !== exp_clk) begin bad++; $display("FAIL idle_clk t=%0d: got %b expected %b", tb_tick, ssp_clk, exp_clk); end
      total++; if (ssp_frame !== exp_frame) begin bad++; $display("FAIL idle_frame t=%0d: got %b expected %b", tb_tick, ssp_frame, exp_frame); end
      total++; if (ssp_din !== 1'b0) begin bad++; $display("FAIL idle_din t=%0d: got %b expected 0", tb_tick, ssp_din); end
    end
  endtask

  task automatic test_single_byte();
    logic [7:0] b;
    send_bits(8'hB2, 4, 16);
    capture_slot(b);
    total++; if (b !== 8'hB2) begin bad++; $display("FAIL single_byte: got %h expected b2", b); end
    capture_slot(b);
    total++; if (b !== 8'h00) begin bad++; $display("FAIL single_idle: got %h expected 00", b); end
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL single_ovf: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    logic [7:0] b;
    send_bits(8'h3C, 8, 1);
    send_bits(8'hA5, 16, 1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_before: got %b expected 0", overflow); end
    // ovf_clr held across the dropping push: the set must win
    ovf_clr = 1'b1;
    send_bits(8'hFF, 24, 1);
    ovf_clr = 1'b0;
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_set: got %b expected 1", overflow); end
    capture_slot(b);
    total++; if (b !== 8'h3C) begin bad++; $display("FAIL ovf_first: got %h expected 3c", b); end
    capture_slot(b);
    total++; if (b !== 8'hA5) begin bad++; $display("FAIL ovf_second: got %h expected a5", b); end
    capture_slot(b);
    total++; if (b !== 8'h00) begin bad++; $display("FAIL ovf_dropped: got %h expected 00", b); end
    total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
    ovf_clr = 1'b1;
    adv();
    ovf_clr = 1'b0;
    adv();
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL ovf_clr: got %b expected 0", overflow); end
  endtask

  task automatic test_collision();
    logic [7:0] b;
    send_bits(8'h11, 8, 1);
    send_bits(8'h22, 16, 1);
    // eighth bit of the third byte lands on tick 0 of the next slot
    send_bits(8'h33, 121, 1);
    total++; if (overflow !== 1'b0) begin bad++; $display("FAIL coll_ovf: got %b expected 0", overflow); end
    capture_slot(b);
    total++; if (b !== 8'h11) begin bad++; $display("FAIL coll_first: got %h expected 11", b); end
    capture_slot(b);
    total++; if (b !== 8'h22) begin bad++; $display("FAIL coll_second: got %h expected 22", b); end
    capture_slot(b);
    total++; if (b !== 8'h33) begin bad++; $display("FAIL coll_third: got %h expected 33", b); end
  endtask

  task automatic test_align();
    logic [7:0] b;
    wait_tick(8);
    for (int i = 0; i < 5; i++) begin
      bit_in = 1'b1; bit_valid = 1'b1;
      adv();
    end
    bit_align = 1'b1;
    adv();
    bit_align = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
    send_bits(8'h5A, 14, 1);
    capture_slot(b);
    total++; if (b !== 8'h5A) begin bad++; $display("FAIL align_byte: got %h expected 5a", b); end
    capture_slot(b);
    total++; if (b !== 8'h00) begin bad++; $display("FAIL align_idle: got %h expected 00", b); end
  endtask

  task automatic test_abort();
    logic [7:0] b;
    send_bits(8'hFF, 8, 1);
    send_bits(8'h81, 16, 1);
    wait_tick(0);
    wait_tick(50);
    total++; if (ssp_din !== 1'b1) begin bad++; $display("FAIL abort_pre_din: got %b expected 1", ssp_din); end
    total++; if (ssp_clk !== 1'b1) begin bad++; $display("FAIL abort_pre_clk: got %b expected 1", ssp_clk); end
    #2 nrst = 1'b0;
    #1;
    total++; if ({ssp_clk, ssp_frame, ssp_din, overflow} !== 4'b0000) begin
      bad++; $display("FAIL abort_outputs: got %b expected 0000", {ssp_clk, ssp_frame, ssp_din, overflow});
    end
    adv(); adv();
    nrst = 1'b1;
    capture_slot(b);
    total++; if (b !== 8'h00) begin bad++; $display("FAIL abort_first_slot: got %h expected 00", b); end
    capture_slot(b);
    total++; if (b !== 8'h00) begin bad++; $display("FAIL abort_second_slot: got %h expected 00", b); end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    tb_tick   = 0;
    nrst      = 1'b0;
    enable    = 1'b0;
    bit_in    = 1'b0;
    bit_valid = 1'b0;
    bit_align = 1'b0;
    ovf_clr   = 1'b0;
    test_reset();
    test_idle();
    test_single_byte();
    test_overflow();
    test_collision();
    test_align();
    test_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
